serial_adder_logic_ops_only: RTL and testbench

//   Bit-serial adder: one bit of operand A and one bit of operand B per clock,
//   LSB first. Emits one sum bit per clock and keeps the carry in a 1-bit register.
//   The implementation uses only the bitwise logic operators &, |, ^ and ~.
//   No +, -, or comparison operators are allowed.

---
 rtl/serial_adder_logic_ops_only_pkg.sv | 20 ++
 rtl/serial_adder_logic_ops_only_fa.sv | 20 ++
 rtl/serial_adder_logic_ops_only.sv | 33 +++
 tb/tb_serial_adder_logic_ops_only.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_logic_ops_only_pkg.sv
// Shared types for the bit-serial adder: the full-adder result pair and
// a logic-only evaluation function used by the adder cell.
package serial_adder_logic_ops_only_pkg;

    typedef struct packed {
        logic s;
        logic cout;
    } fa_result_t;

    // Built from &, |, ^ only so the cell never infers an arithmetic adder.
    function automatic fa_result_t fa_eval(input logic a, input logic b, input logic cin);
        fa_result_t r;
        logic       p;
        p      = a ^ b;
        r.s    = p ^ cin;
        r.cout = (a & b) | (cin & p);
        return r;
    endfunction

endpackage

// File: rtl/serial_adder_logic_ops_only_fa.sv
// Combinational full-adder cell built purely from bitwise logic operators.
module full_adder_logic
    import serial_adder_logic_ops_only_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    fa_result_t res;

    always_comb begin
        res  = fa_eval(a, b, cin);
        s    = res.s;
        cout = res.cout;
    end

endmodule

// File: rtl/serial_adder_logic_ops_only.sv
// Bit-serial adder, LSB first: one full-adder cell plus a single carry flop.
// The sum bit is combinational from the current operand bits and the stored carry.
module serial_adder_logic_ops_only
    import serial_adder_logic_ops_only_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic a,
    input  logic b,
    output logic sum
);

    logic carry_reg;
    logic carry_next;

    full_adder_logic u_fa (
        .a    (a),
        .b    (b),
        .cin  (carry_reg),
        .s    (sum),
        .cout (carry_next)
    );

    // Reset discards any carry in flight so the next bit starts a fresh addition.
    always_ff @(posedge clk) begin
        if (rst) begin
            carry_reg <= 1'b0;
        end else begin
            carry_reg <= carry_next;
        end
    end

endmodule

// File: tb/tb_serial_adder_logic_ops_only.sv
// Directed and random checks of the bit-serial adder against a behavioural
// arithmetic reference model of the original serial_adder.
module tb_serial_adder_logic_ops_only;

    logic clk;
    logic rst;
    logic a;
    logic b;
    logic sum;

    int n_checks;
    int n_fail;

    // Behavioural reference carry, updated with arithmetic after each checked cycle.
    logic       ref_carry;
    logic [1:0] ref_total;

    serial_adder_logic_ops_only dut (
        .clk (clk),
        .rst (rst),
        .a   (a),
        .b   (b),
        .sum (sum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one cycle of inputs just after a rising edge; return at the falling edge.
    task automatic drive(input logic ai, input logic bi, input logic ri);
        @(posedge clk);
        #1;
        a   = ai;
        b   = bi;
        rst = ri;
        @(negedge clk);
    endtask

    // Advance the reference to the state it will have after the coming rising edge.
    task automatic ref_step();
        if (rst) begin
            ref_carry = 1'b0;
        end else begin
            ref_total = {1'b0, a} + {1'b0, b} + {1'b0, ref_carry};
            ref_carry = ref_total[1];
        end
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 1'b1);
        n_checks++;
        if (sum !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_hold_a1b0: sum=%b expected 1", sum);
        end
        drive(1'b1, 1'b1, 1'b1);
        n_checks++;
        if (sum !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hold_a1b1: sum=%b expected 0", sum);
        end
        drive(1'b0, 1'b1, 1'b0);
        n_checks++;
        if (sum !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_first_bit: sum=%b expected 1", sum);
        end
        $display("test_reset done");
    endtask

    task automatic run_stream(input string name, input logic [15:0] va, input logic [15:0] vb,
                              input logic [15:0] vexp);
        logic [15:0] got;
        drive(1'b0, 1'b0, 1'b1);
        ref_carry = 1'b0;
        got = '0;
        for (int i = 0; i < 16; i++) begin
            drive(va[i], vb[i], 1'b0);
            got[i] = sum;
            ref_total = {1'b0, a} + {1'b0, b} + {1'b0, ref_carry};
            n_checks++;
            if (sum !== ref_total[0]) begin
                n_fail++;
                $display("FAIL %s_ref_bit%0d: sum=%b expected %b", name, i, sum, ref_total[0]);
            end
            ref_step();
        end
        n_checks++;
        if (got !== vexp) begin
            n_fail++;
            $display("FAIL %s_word: sum=%h expected %h", name, got, vexp);
        end
        $display("%s: A=%h B=%h sum=%h", name, va, vb, got);
    endtask

    task automatic test_vector();
        run_stream("vector", 16'b1000_0001_1001_0010, 16'b0010_0001_0101_0100,
                   16'b1010_0010_1110_0110);
    endtask

    task automatic test_ripple();
        run_stream("ripple", 16'hFFFF, 16'h0001, 16'h0000);
        // The lost carry-out must not leak into a new operand after reset.
        drive(1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0);
        n_checks++;
        if (sum !== 1'b0) begin
            n_fail++;
            $display("FAIL ripple_after_reset: sum=%b expected 0", sum);
        end
    endtask

    task automatic test_carry_in();
        logic [2:0] exp_s;
        logic [2:0] got;
        exp_s = 3'b010;
        drive(1'b0, 1'b0, 1'b1);
        drive(1'b1, 1'b1, 1'b0);
        got[0] = sum;
        drive(1'b0, 1'b0, 1'b0);
        got[1] = sum;
        drive(1'b0, 1'b0, 1'b0);
        got[2] = sum;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (got[i] !== exp_s[i]) begin
                n_fail++;
                $display("FAIL carry_in_cycle%0d: sum=%b expected %b", i, got[i], exp_s[i]);
            end
        end
        $display("test_carry_in: sums c0=%b c1=%b c2=%b", got[0], got[1], got[2]);
    endtask

    task automatic test_reset_midstream();
        drive(1'b0, 1'b0, 1'b1);
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b1);
        drive(1'b1, 1'b0, 1'b0);
        n_checks++;
        if (sum !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_midstream: sum=%b expected 1", sum);
        end
        $display("test_reset_midstream: sum=%b", sum);
    endtask

    task automatic test_exhaustive();
        logic ai, bi, ci, es, ec;
        for (int k = 0; k < 8; k++) begin
            ai = k[2];
            bi = k[1];
            ci = k[0];
            es = ai ^ bi ^ ci;
            ec = (ai & bi) | (ai & ci) | (bi & ci);
            drive(1'b0, 1'b0, 1'b1);
            if (ci) drive(1'b1, 1'b1, 1'b0);
            drive(ai, bi, 1'b0);
            n_checks++;
            if (sum !== es) begin
                n_fail++;
                $display("FAIL cell_sum_abc%0d%0d%0d: sum=%b expected %b", ai, bi, ci, sum, es);
            end
            drive(1'b0, 1'b0, 1'b0);
            n_checks++;
            if (sum !== ec) begin
                n_fail++;
                $display("FAIL cell_cout_abc%0d%0d%0d: sum=%b expected %b", ai, bi, ci, sum, ec);
            end
            $display("cell a=%b b=%b c=%b: s=%b cout=%b", ai, bi, ci, es, ec);
        end
    endtask

    task automatic test_random();
        int errs_before;
        errs_before = n_fail;
        drive(1'b0, 1'b0, 1'b1);
        ref_carry = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0);
            ref_total = {1'b0, a} + {1'b0, b} + {1'b0, ref_carry};
            n_checks++;
            if (sum !== ref_total[0]) begin
                n_fail++;
                $display("FAIL random_cycle%0d: sum=%b expected %b", i, sum, ref_total[0]);
            end
            ref_step();
        end
        $display("test_random: 1000 cycles, %0d new failures", n_fail - errs_before);
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        ref_carry = 1'b0;
        ref_total = '0;
        a   = 1'b0;
        b   = 1'b0;
        rst = 1'b1;
        test_reset();
        test_vector();
        test_ripple();
        test_carry_in();
        test_reset_midstream();
        test_exhaustive();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
